// File: rtl/ertn_ctrl.sv
// ertn_ctrl: exception-return sequencer and CRMD owner.
// Exception entry demotes CRMD (PLV/IE cleared) and exports CRMD[2:0] for the
// PRMD save. A committed ERTN drains the store buffer, restores CRMD[2:0] from
// PRMD, then issues a one-cycle flush and fetch redirect to the latched ERA.
module ertn_ctrl #(
  parameter logic [31:0] CRMD_RST = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ertn_commit,
  input  logic        except_en,
  input  logic        CSRWR_CRMD_en,
  input  logic [31:0] CSRWR_CRMD_data,
  input  logic [2:0]  PRMD_3,
  input  logic [31:0] ERA,
  input  logic        sb_empty,
  output logic [31:0] CRMD,
  output logic [2:0]  CRMD_3,
  output logic        stall_commit,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_RESTORE  = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  state_t      r_state;
  logic [4:0]  r_crmd;     // implemented CRMD bits: PG, DA, IE, PLV[1:0]
  logic [31:0] r_era_q;    // return target, captured once at ERTN acceptance

  logic        w_in_redirect;
  logic        w_unused_csr_hi;

  // Sequencer state, CRMD and captured ERA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_crmd  <= CRMD_RST[4:0];
      r_era_q <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // CSR write covers every bit the exception would clear, so it wins
          // outright when both arrive together.
          if (CSRWR_CRMD_en) begin
            r_crmd <= CSRWR_CRMD_data[4:0];
          end else if (except_en) begin
            r_crmd[2:0] <= 3'b000;
          end
          // An exception in the same cycle cancels the ERTN.
          if (ertn_commit && !except_en) begin
            r_era_q <= ERA;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (sb_empty) begin
            r_state <= S_RESTORE;
          end
        end
        S_RESTORE: begin
          r_crmd[2:0] <= PRMD_3;
          r_state     <= S_REDIRECT;
        end
        S_REDIRECT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_in_redirect   = (r_state == S_REDIRECT);
  assign w_unused_csr_hi = ^CSRWR_CRMD_data[31:5];

  // Outputs are pure decodes of registered state, hence glitch-free.
  assign CRMD           = {27'b0, r_crmd};
  assign CRMD_3         = r_crmd[2:0];
  assign stall_commit   = (r_state != S_IDLE);
  assign flush          = w_in_redirect;
  assign redirect_valid = w_in_redirect;
  assign redirect_pc    = w_in_redirect ? r_era_q : '0;

endmodule

// File: tb/tb_ertn_ctrl.sv
// tb_ertn_ctrl: directed vectors with hand-computed expectations for ertn_ctrl.
module tb_ertn_ctrl;

  logic        clk;
  logic        rst;
  logic        ertn_commit;
  logic        except_en;
  logic        CSRWR_CRMD_en;
  logic [31:0] CSRWR_CRMD_data;
  logic [2:0]  PRMD_3;
  logic [31:0] ERA;
  logic        sb_empty;
  logic [31:0] CRMD;
  logic [2:0]  CRMD_3;
  logic        stall_commit;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int unsigned n_vec;
  int unsigned n_bad;

  ertn_ctrl #(.CRMD_RST(32'h0000_0008)) dut (
    .clk             (clk),
    .rst             (rst),
    .ertn_commit     (ertn_commit),
    .except_en       (except_en),
    .CSRWR_CRMD_en   (CSRWR_CRMD_en),
    .CSRWR_CRMD_data (CSRWR_CRMD_data),
    .PRMD_3          (PRMD_3),
    .ERA             (ERA),
    .sb_empty        (sb_empty),
    .CRMD            (CRMD),
    .CRMD_3          (CRMD_3),
    .stall_commit    (stall_commit),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] crmd_e, input logic stall_e,
                         input logic fl_e, input logic [31:0] pc_e);
    chk({tag, ".crmd"},  CRMD, crmd_e);
    chk({tag, ".crmd3"}, {29'b0, CRMD_3}, {29'b0, crmd_e[2:0]});
    chk({tag, ".stall"}, {31'b0, stall_commit}, {31'b0, stall_e});
    chk({tag, ".flush"}, {31'b0, flush}, {31'b0, fl_e});
    chk({tag, ".rv"},    {31'b0, redirect_valid}, {31'b0, fl_e});
    chk({tag, ".pc"},    redirect_pc, pc_e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    ertn_commit = 1'b0;
    except_en = 1'b0;
    CSRWR_CRMD_en = 1'b0;
    CSRWR_CRMD_data = '0;
    PRMD_3 = 3'b000;
    ERA = '0;
    sb_empty = 1'b1;

    // Reset, then idle for 10 cycles.
    step();
    chk_out("rst", 32'h8, 1'b0, 1'b0, 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out("idle", 32'h8, 1'b0, 1'b0, 32'h0);
    end

    // CSR write then exception entry.
    CSRWR_CRMD_en = 1'b1;
    CSRWR_CRMD_data = 32'h0000_0007;
    step();
    CSRWR_CRMD_en = 1'b0;
    chk("csrwr7", CRMD, 32'h7);
    except_en = 1'b1;
    step();
    except_en = 1'b0;
    chk_out("exc", 32'h0, 1'b0, 1'b0, 32'h0);

    // ERTN with empty store buffer; a second ERTN asserted during REDIRECT is
    // ignored, and held into the following IDLE cycle it is accepted.
    PRMD_3 = 3'b111;
    ERA = 32'h1C00_0040;
    sb_empty = 1'b1;
    ertn_commit = 1'b1;
    step();                                   // T+1 DRAIN
    ertn_commit = 1'b0;
    chk_out("e1.t1", 32'h0, 1'b1, 1'b0, 32'h0);
    step();                                   // T+2 RESTORE
    chk_out("e1.t2", 32'h0, 1'b1, 1'b0, 32'h0);
    step();                                   // T+3 REDIRECT
    chk_out("e1.t3", 32'h7, 1'b1, 1'b1, 32'h1C00_0040);
    ertn_commit = 1'b1;
    step();                                   // T+4 IDLE, ertn accepted here
    chk_out("e1.t4", 32'h7, 1'b0, 1'b0, 32'h0);
    step();
    ertn_commit = 1'b0;
    chk_out("b2b.t1", 32'h7, 1'b1, 1'b0, 32'h0);
    step();
    chk_out("b2b.t2", 32'h7, 1'b1, 1'b0, 32'h0);
    step();
    chk_out("b2b.t3", 32'h7, 1'b1, 1'b1, 32'h1C00_0040);
    step();
    chk_out("b2b.t4", 32'h7, 1'b0, 1'b0, 32'h0);

    // ERTN with 4-cycle drain; ERA changes after capture; commit-side
    // inputs pulsed mid-DRAIN must have no effect.
    PRMD_3 = 3'b010;
    sb_empty = 1'b0;
    ertn_commit = 1'b1;
    step();                                   // T+1
    ertn_commit = 1'b0;
    ERA = 32'hDEAD_BEEF;
    chk_out("e2.t1", 32'h7, 1'b1, 1'b0, 32'h0);
    for (int i = 2; i <= 6; i++) begin
      step();
      if (i == 3) begin
        except_en = 1'b1;
        CSRWR_CRMD_en = 1'b1;
        CSRWR_CRMD_data = 32'h0;
        ertn_commit = 1'b1;
      end else begin
        except_en = 1'b0;
        CSRWR_CRMD_en = 1'b0;
        ertn_commit = 1'b0;
      end
      if (i == 5) sb_empty = 1'b1;
      chk_out("e2.wait", 32'h7, 1'b1, 1'b0, 32'h0);
    end
    step();                                   // T+7 REDIRECT
    chk_out("e2.t7", 32'h2, 1'b1, 1'b1, 32'h1C00_0040);
    step();
    chk_out("e2.t8", 32'h2, 1'b0, 1'b0, 32'h0);

    // ERTN colliding with exception: exception wins, no DRAIN.
    ERA = 32'h1C00_0040;
    ertn_commit = 1'b1;
    except_en = 1'b1;
    step();
    ertn_commit = 1'b0;
    except_en = 1'b0;
    chk_out("col.ertn", 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    chk_out("col.ertn2", 32'h0, 1'b0, 1'b0, 32'h0);

    // CSR write colliding with exception: CSR write wins.
    CSRWR_CRMD_en = 1'b1;
    CSRWR_CRMD_data = 32'h0000_001F;
    except_en = 1'b1;
    step();
    except_en = 1'b0;
    CSRWR_CRMD_en = 1'b0;
    chk_out("col.csr", 32'h1F, 1'b0, 1'b0, 32'h0);

    // Upper CRMD bits ignore writes.
    CSRWR_CRMD_en = 1'b1;
    CSRWR_CRMD_data = 32'hFFFF_FFF0;
    step();
    CSRWR_CRMD_en = 1'b0;
    chk("csr.hi", CRMD, 32'h0000_0010);

    // Reset during RESTORE: immediate return, no flush afterwards.
    PRMD_3 = 3'b111;
    sb_empty = 1'b1;
    ertn_commit = 1'b1;
    step();                                   // DRAIN
    ertn_commit = 1'b0;
    step();                                   // RESTORE
    chk_out("rr.restore", 32'h10, 1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    chk_out("rr.async", 32'h8, 1'b0, 1'b0, 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out("rr.after", 32'h8, 1'b0, 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
